// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic result drain.
// DRAIN_SAT_EN selects the saturated (WIDTH-bit) output stream.
package systolic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned out_w(input int unsigned width);
`ifdef DRAIN_SAT_EN
    return width;
`else
    return 2 * width;
`endif
  endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Capture/stream bundle between the systolic array side and the drain.
// master: the drain; slave: the environment feeding and consuming it.
interface systolic_drain_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned I     = 4,
  parameter int unsigned J     = 4
) ();
  import systolic_pkg::*;

  localparam int unsigned OUT_W = out_w(WIDTH);
  localparam int unsigned RW    = idx_w(I);
  localparam int unsigned CW    = idx_w(J);

  logic [2*WIDTH*I*J-1:0] result_in;
  logic                   capture_valid;
  logic                   capture_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          out_row;
  logic [CW-1:0]          out_col;
  logic                   out_last;

  modport master (
    input  result_in, capture_valid, out_ready,
    output capture_ready, out_data, out_valid, out_row, out_col, out_last
  );

  modport slave (
    output result_in, capture_valid, out_ready,
    input  capture_ready, out_data, out_valid, out_row, out_col, out_last
  );

endinterface

// File: rtl/systolic_drain_sat_clip.sv
// Signed saturation of a 2*WIDTH element down to WIDTH bits.
// Only compiled when DRAIN_SAT_EN is defined.
`ifdef DRAIN_SAT_EN
module sat_clip #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] in_i,
  output logic [WIDTH-1:0]   out_o
);
  logic [WIDTH:0] upper;
  logic           fits;

  always_comb begin
    upper = in_i[2*WIDTH-1:WIDTH-1];
    fits  = (&upper) | ~(|upper);
    if (fits)
      out_o = in_i[WIDTH-1:0];
    else if (in_i[2*WIDTH-1])
      out_o = {1'b1, {(WIDTH-1){1'b0}}};
    else
      out_o = {1'b0, {(WIDTH-1){1'b1}}};
  end
endmodule
`endif

// File: rtl/systolic_drain.sv
// Snapshots an I x J result array and streams it out row-major, one beat per handshake.
// DRAIN_SAT_EN: elements are signed-saturated to WIDTH bits via sat_clip.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned I     = 4,
  parameter int unsigned J     = 4
) (
  input logic              clk,
  input logic              rst_n,
  systolic_drain_if.master bus
);
  localparam int unsigned N     = I * J;
  localparam int unsigned OUT_W = out_w(WIDTH);
  localparam int unsigned RW    = idx_w(I);
  localparam int unsigned CW    = idx_w(J);
  localparam int unsigned KW    = idx_w(N);
  localparam logic [RW-1:0] ROW_LAST = RW'(I - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(J - 1);

  drain_state_t state_q, state_d;
  logic [KW-1:0] idx_q, idx_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [2*WIDTH-1:0] snap_q [N];
  logic [2*WIDTH-1:0] elem;
  logic [OUT_W-1:0]   elem_out;
  logic capture, fire, at_last;

  assign capture = (state_q == IDLE) && bus.capture_valid;
  assign fire    = (state_q == STREAM) && bus.out_ready;
  assign at_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign elem    = snap_q[idx_q];

`ifdef DRAIN_SAT_EN
  sat_clip #(.WIDTH(WIDTH)) u_sat (.in_i(elem), .out_o(elem_out));
`else
  assign elem_out = elem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.capture_valid) state_d = STREAM;
      STREAM:  if (bus.out_ready && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.capture_ready = (state_q == IDLE);
    bus.out_valid     = (state_q == STREAM);
    bus.out_data      = (state_q == STREAM) ? elem_out : '0;
    bus.out_row       = row_q;
    bus.out_col       = col_q;
    bus.out_last      = (state_q == STREAM) && at_last;
  end

  // Index, row and column advance together so no divider is needed for row/col.
  always_comb begin
    idx_d = idx_q;
    row_d = row_q;
    col_d = col_q;
    if (capture) begin
      idx_d = '0;
      row_d = '0;
      col_d = '0;
    end else if (fire) begin
      if (at_last) begin
        idx_d = '0;
        row_d = '0;
        col_d = '0;
      end else begin
        idx_d = idx_q + KW'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      idx_q <= idx_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) snap_q[k] <= '0;
    end else if (capture) begin
      for (int unsigned k = 0; k < N; k++)
        snap_q[k] <= bus.result_in[2*WIDTH*k +: 2*WIDTH];
    end
  end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; each array result element is 2*WIDTH bits, two's complement.
REQ-002 SHALL have parameter I, default 4: number of array rows.
REQ-003 SHALL have parameter J, default 4: number of array columns.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port result_in  input  2*WIDTH*I*J  flattened array results; element (i,j) is at bit offset 2*WIDTH*(i*J+j).
REQ-007 SHALL have port capture_valid  input  1  request to snapshot result_in.
REQ-008 SHALL have port capture_ready  output  1  high exactly when in IDLE.
REQ-009 SHALL have port out_data  output  OUT_W  streamed element; OUT_W is set in REQ-027.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-012 SHALL have port out_row  output  clog2(I) (min 1)  row index of the current beat.
REQ-013 SHALL have port out_col  output  clog2(J) (min 1)  column index of the current beat.
REQ-014 SHALL have port out_last  output  1  current beat is element (I-1,J-1).

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and STREAM.
REQ-016 IDLE: on capture_valid=1, SHALL register all I*J elements of result_in into a snapshot buffer, set index to 0 and go to STREAM.
REQ-017 A capture at edge N SHALL produce out_valid=1 from cycle N+1.
REQ-018 STREAM: SHALL hold out_valid=1 and drive out_data, out_row, out_col from snapshot[index].
REQ-019 A beat SHALL transfer when out_valid and out_ready are both 1 on a rising edge; index then advances by 1.
REQ-020 Streaming order SHALL be row-major: index k maps to row k/J and column k%J.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-022 When the beat with out_last=1 transfers, SHALL return to IDLE with out_valid=0 the next cycle; index wraps to 0.
REQ-023 capture_valid in STREAM SHALL be ignored (capture_ready=0); the snapshot SHALL not change.
REQ-024 capture_valid in the same cycle as the final transfer SHALL be ignored and accepted only once back in IDLE; back-to-back throughput is I*J+1 cycles per snapshot.
REQ-025 With out_ready held at 1, SHALL emit one beat per cycle.

Reset
REQ-026 With rst_n=0: state=IDLE, index=0, snapshot=0, out_valid=0, out_data=0, out_last=0, out_row=0, out_col=0, capture_ready=1; a reset mid-stream SHALL abandon the remaining beats.

Configuration
REQ-027 Macro DRAIN_SAT_EN defined: OUT_W=WIDTH, and each element SHALL be signed-saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-028 Macro DRAIN_SAT_EN undefined: OUT_W=2*WIDTH, and elements SHALL pass through unchanged.

Structure
REQ-029 FSM state encodings and the OUT_W computation SHALL live in shared package systolic_pkg.
REQ-030 Saturation SHALL be a combinational sub-module sat_clip (input 2*WIDTH, output WIDTH), instantiated only under DRAIN_SAT_EN.

Verification (WIDTH=16, I=J=4)
REQ-031 Release reset, no stimulus -> out_valid=0, capture_ready=1, out_data=0.
REQ-032 Element k=k+1, one capture pulse, out_ready=1 -> 16 consecutive beats 1..16; row/col (0,0)..(3,3); out_last on beat 16 only; capture_ready=1 the following cycle.
REQ-033 Same snapshot, out_ready alternating 1,0 -> exactly 16 beats with unchanged values; outputs stable on every stalled cycle.
REQ-034 capture_valid=1 with a new pattern (all 0xAA) during beat 3 -> ignored; remaining beats keep the original values 4..16.
REQ-035 Under DRAIN_SAT_EN: 32'h0001_0000 -> 16'h7FFF; 32'hFFFF_0000 -> 16'h8000; 32'h0000_1234 -> 16'h1234. Without the macro: all three pass through as 32 bits.
REQ-036 rst_n asserted after beat 5 -> out_valid=0 immediately, capture_ready=1; a fresh capture then streams from (0,0).
